// File: rtl/tdm_demultiplexer_if.sv
// tdm_demultiplexer_if: bus between a word-serial TDM source and the demultiplexer.
//   din/din_valid/sof : incoming channel word, its qualifier and the start-of-frame mark
//   dout              : last complete frame, channel k at [k*WIDTH +: WIDTH]
//   frame_valid       : one-cycle pulse when dout has just been updated
//   frame_err         : one-cycle pulse on a framing error
//   locked            : level, high while aligned to the frame structure
//   frame_cnt         : completed-frame count, wraps 255 -> 0
// master = stream source / frame consumer, slave = demultiplexer.
interface tdm_demultiplexer_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
);
    logic [WIDTH-1:0]          din;
    logic                      din_valid;
    logic                      sof;
    logic [CHANNELS*WIDTH-1:0] dout;
    logic                      frame_valid;
    logic                      frame_err;
    logic                      locked;
    logic [7:0]                frame_cnt;

    modport master (
        output din, din_valid, sof,
        input  dout, frame_valid, frame_err, locked, frame_cnt
    );

    modport slave (
        input  din, din_valid, sof,
        output dout, frame_valid, frame_err, locked, frame_cnt
    );
endinterface

// File: rtl/tdm_demultiplexer.sv
// tdm_demultiplexer: restores CHANNELS interleaved channel words into a parallel frame.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : tdm_demultiplexer_if.slave (stream in, frame/status out)
// Channels 0..CHANNELS-2 are held in a shadow bank; the final word goes straight
// into dout together with the shadow bank, so dout only changes on a full frame.
module tdm_demultiplexer #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tdm_demultiplexer_if.slave    bus
);
    localparam int unsigned IW = $clog2(CHANNELS);
    localparam logic [IW-1:0] LAST = IW'(CHANNELS - 1);

    typedef enum logic {HUNT, COLLECT} state_t;

    state_t                    state, state_next;
    logic [IW-1:0]             idx, idx_next;
    logic [WIDTH-1:0]          shadow [CHANNELS-1];
    logic [CHANNELS*WIDTH-1:0] dout_q;
    logic                      frame_valid_q, frame_err_q, locked_q;
    logic [7:0]                frame_cnt_q;

    logic                      shadow_wr;
    logic [IW-1:0]             wr_idx;
    logic                      complete;
    logic                      err_next;
    logic                      locked_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        shadow_wr   = 1'b0;
        complete    = 1'b0;
        err_next    = 1'b0;
        locked_next = locked_q;
        // sof always restarts at channel 0; otherwise write at the running index
        wr_idx      = bus.sof ? '0 : idx;
        if (bus.din_valid) begin
            unique case (state)
                HUNT: begin
                    if (bus.sof) begin
                        shadow_wr  = 1'b1;
                        idx_next   = IW'(1);
                        state_next = COLLECT;
                    end else if (locked_q) begin
                        err_next    = 1'b1;
                        locked_next = 1'b0;
                    end
                end
                COLLECT: begin
                    if (bus.sof) begin
                        shadow_wr   = 1'b1;
                        idx_next    = IW'(1);
                        err_next    = 1'b1;
                        locked_next = 1'b0;
                    end else if (idx == LAST) begin
                        complete    = 1'b1;
                        idx_next    = '0;
                        locked_next = 1'b1;
                        state_next  = HUNT;
                    end else begin
                        shadow_wr = 1'b1;
                        idx_next  = idx + IW'(1);
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < CHANNELS - 1; k++) shadow[k] <= '0;
            dout_q        <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            locked_q      <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            for (int unsigned k = 0; k < CHANNELS - 1; k++) begin
                if (shadow_wr && wr_idx == IW'(k)) shadow[k] <= bus.din;
            end
            if (complete) begin
                for (int unsigned k = 0; k < CHANNELS - 1; k++) begin
                    dout_q[k*WIDTH +: WIDTH] <= shadow[k];
                end
                dout_q[(CHANNELS-1)*WIDTH +: WIDTH] <= bus.din;
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            frame_valid_q <= complete;
            frame_err_q   <= err_next;
            locked_q      <= locked_next;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.locked      = locked_q;
    assign bus.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_tdm_demultiplexer.sv
module tb_tdm_demultiplexer;
    localparam int CH = 4;
    localparam int W  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tdm_demultiplexer_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

    tdm_demultiplexer #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int fv_seen = 0;
    bit chk_en = 1'b0;

    // Reference model: a queue holds the words of the frame being gathered;
    // an empty queue means "waiting for a start of frame".
    logic [7:0]      part [$];
    logic [CH*W-1:0] exp_dout;
    logic            exp_fv, exp_fe, exp_locked;
    logic [7:0]      exp_cnt;

    task automatic model_reset();
        part.delete();
        exp_dout   = '0;
        exp_fv     = 1'b0;
        exp_fe     = 1'b0;
        exp_locked = 1'b0;
        exp_cnt    = '0;
    endtask

    task automatic model_word(input logic v, input logic s, input logic [7:0] d);
        exp_fv = 1'b0;
        exp_fe = 1'b0;
        if (v) begin
            if (s) begin
                if (part.size() != 0) begin
                    exp_fe     = 1'b1;
                    exp_locked = 1'b0;
                end
                part.delete();
                part.push_back(d);
            end else if (part.size() == 0) begin
                if (exp_locked) begin
                    exp_fe     = 1'b1;
                    exp_locked = 1'b0;
                end
            end else begin
                part.push_back(d);
                if (part.size() == CH) begin
                    for (int k = 0; k < CH; k++) exp_dout[k*W +: W] = part[k];
                    exp_fv     = 1'b1;
                    exp_locked = 1'b1;
                    exp_cnt    = exp_cnt + 8'd1;
                    part.delete();
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of input, let the model see the same edge, return 1 time unit after it.
    task automatic step(input logic v, input logic s, input logic [7:0] d);
        bus.din_valid = v;
        bus.sof       = s;
        bus.din       = d;
        @(posedge clk);
        if (rst_n) model_word(v, s, d);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dout",        bus.dout,        exp_dout);
            chk("frame_valid", 32'(bus.frame_valid), 32'(exp_fv));
            chk("frame_err",   32'(bus.frame_err),   32'(exp_fe));
            chk("locked",      32'(bus.locked),      32'(exp_locked));
            chk("frame_cnt",   32'(bus.frame_cnt),   32'(exp_cnt));
            if (bus.frame_valid) fv_seen++;
        end
    end

    initial begin
        int base;
        int p;
        logic v, s;
        bus.din_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.din       = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset values
        chk("rst_dout",   bus.dout, 32'h0);
        chk("rst_locked", 32'(bus.locked), 32'h0);
        chk("rst_cnt",    32'(bus.frame_cnt), 32'h0);
        chk("rst_pulses", 32'({bus.frame_valid, bus.frame_err}), 32'h0);
        rst_n = 1'b1;
        step(0, 0, 8'h00);

        // Single frame
        step(1, 1, 8'h11);
        step(1, 0, 8'h22);
        step(1, 0, 8'h33);
        step(1, 0, 8'h44);
        chk("s2_dout", bus.dout, 32'h44332211);
        chk("s2_fv",   32'(bus.frame_valid), 32'h1);
        step(0, 0, 8'h00);
        chk("s2_fv_off", 32'(bus.frame_valid), 32'h0);
        chk("s2_locked", 32'(bus.locked), 32'h1);
        chk("s2_cnt",    32'(bus.frame_cnt), 32'h1);

        // Missing start of frame after lock
        step(1, 0, 8'h55);
        chk("s5_fe",     32'(bus.frame_err), 32'h1);
        chk("s5_locked", 32'(bus.locked), 32'h0);
        chk("s5_dout",   bus.dout, 32'h44332211);
        step(0, 0, 8'h00);

        // Gapped stream
        base = fv_seen;
        for (int k = 0; k < 4; k++) begin
            step(1, k == 0, 8'(8'h11 * (k + 1)));
            repeat (3) step(0, 0, 8'hEE);
        end
        chk("s3_dout",   bus.dout, 32'h44332211);
        chk("s3_pulses", 32'(fv_seen - base), 32'h1);
        chk("s3_cnt",    32'(bus.frame_cnt), 32'h2);

        // Premature start of frame
        base = fv_seen;
        step(1, 1, 8'hA0);
        step(1, 0, 8'hA1);
        step(1, 1, 8'hB0);
        chk("s4_fe",     32'(bus.frame_err), 32'h1);
        chk("s4_locked", 32'(bus.locked), 32'h0);
        step(1, 0, 8'hB1);
        step(1, 0, 8'hB2);
        step(1, 0, 8'hB3);
        step(0, 0, 8'h00);
        chk("s4_dout",   bus.dout, 32'hB3B2B1B0);
        chk("s4_pulses", 32'(fv_seen - base), 32'h1);

        // Randomized stream with occasional framing faults
        p = 0;
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            s = (p == 0);
            if ($urandom_range(0, 19) == 0) s = ~s;
            step(v, s, 8'($urandom));
            if (v) p = (s ? 1 : p + 1) % CH;
        end

        // Continuous run and wrap
        rst_n = 1'b0;
        model_reset();
        step(0, 0, 8'h00);
        rst_n = 1'b1;
        step(0, 0, 8'h00);
        base = fv_seen;
        for (int f = 0; f < 256; f++) begin
            for (int k = 0; k < CH; k++) step(1, k == 0, 8'($urandom));
        end
        step(0, 0, 8'h00);
        chk("s6_pulses", 32'(fv_seen - base), 32'd256);
        chk("s6_cnt",    32'(bus.frame_cnt), 32'h0);
        chk("s6_locked", 32'(bus.locked), 32'h1);
        for (int k = 0; k < CH; k++) step(1, k == 0, 8'hC0 + 8'(k));
        step(1, 1, 8'hD0);
        step(1, 0, 8'hD1);

        // Reset asserted while the third word is on the bus
        bus.din_valid = 1'b1;
        bus.sof       = 1'b0;
        bus.din       = 8'hD2;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mr_dout",   bus.dout, 32'h0);
        chk("mr_locked", 32'(bus.locked), 32'h0);
        chk("mr_cnt",    32'(bus.frame_cnt), 32'h0);
        chk("mr_pulses", 32'({bus.frame_valid, bus.frame_err}), 32'h0);
        step(1, 0, 8'hD3);
        rst_n = 1'b1;
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        chk("mr_after", 32'({bus.frame_valid, bus.frame_err, bus.locked}), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tdm_demultiplexer.md
# tdm_demultiplexer

Time-division demultiplexer: receives a word-serial stream in which CHANNELS channel words are interleaved frame by frame and fans them back out to per-channel parallel outputs. It is the receive-side counterpart of the team's multiplexer blocks: where those select one of several sources onto one line, this block takes the shared line and restores the individual channels. It presents each completed frame as one registered update, and it reports framing errors and synchronisation state.

## Interface
- `CHANNELS`, default 4: number of interleaved channels per frame. Legal range is 2 to 16.
- `WIDTH`, default 8: bits per channel word.
- `clk`, input, 1 bit: the single clock; all logic is on the rising edge.
- `rst_n`, input, 1 bit: reset, asynchronous and active-low.
- `din`, input, WIDTH bits: incoming channel word.
- `din_valid`, input, 1 bit: `din` is valid this cycle. There is no backpressure; every valid word is consumed.
- `sof`, input, 1 bit: start of frame. It is meaningful only when `din_valid` is high, and it marks the channel-0 word.
- `dout`, output, CHANNELS*WIDTH bits: last complete frame. Channel k is at `[k*WIDTH +: WIDTH]`.
- `frame_valid`, output, 1 bit: one-cycle pulse when `dout` has just been updated.
- `frame_err`, output, 1 bit: one-cycle pulse on a framing error.
- `locked`, output, 1 bit: level; high while the block is aligned to the frame structure.
- `frame_cnt`, output, 8 bits: count of completed frames, wrapping from 255 to 0.

## Operation
- State machine with two states:
  - HUNT: waiting for `sof`.
  - COLLECT: gathering channels 1 to CHANNELS-1.
- Internal storage:
  - channel index `idx`, sized `$clog2(CHANNELS)`;
  - a shadow register bank of CHANNELS-1 words, holding channels 0 to CHANNELS-2;
  - the output bank `dout`, which is written only when a frame completes.
- HUNT, valid word with `sof`=1: store it in shadow[0], set `idx`=1, go to COLLECT.
- HUNT, valid word with `sof`=0: drop the word.
  - If `locked`=1: clear `locked` and pulse `frame_err` (the expected `sof` was missing).
  - If `locked`=0: nothing else happens; the block is simply still hunting.
- COLLECT, valid word with `sof`=0 and `idx` < CHANNELS-1: store it in shadow[idx], then increment `idx`.
- COLLECT, valid word with `sof`=0 and `idx` = CHANNELS-1 (frame complete):
  - load `dout` from shadow[0..CHANNELS-2] plus the current word as channel CHANNELS-1;
  - pulse `frame_valid`, set `locked`=1, increment `frame_cnt`;
  - return to HUNT with `idx`=0.
- COLLECT, valid word with `sof`=1 (premature start of frame):
  - discard the partial frame and pulse `frame_err`;
  - store the word in shadow[0], set `idx`=1, stay in COLLECT;
  - clear `locked`.
- `din_valid`=0: no state change in any state. Gaps between words, including gaps inside a frame, are legal.
- `dout` holds its value between frames. A partial or errored frame never modifies `dout`.
- `frame_valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset (asynchronous assert, synchronous use after deassert):
  - state HUNT, `idx`=0, shadow all 0;
  - `dout`=0, `frame_valid`=0, `frame_err`=0, `locked`=0, `frame_cnt`=0.
- Latency: the last word of a frame is sampled at edge N. At edge N, `dout` and `frame_cnt` update and `frame_valid` goes high. All three are visible in cycle N+1, and `frame_valid` is low again after edge N+1 unless another frame completes.
- `frame_err` is registered and is visible in the cycle after the offending word's edge.
- Back-to-back frames at full rate, with `din_valid` held at 1 and `sof` every CHANNELS cycles:
  - `frame_valid` pulses every CHANNELS cycles;
  - no words are lost;
  - `locked` stays at 1.
- Reset asserted mid-frame: everything clears immediately. The partial frame is lost and no pulse is emitted.
- All outputs are driven directly from flops.

## Test plan
All scenarios use CHANNELS=4 and WIDTH=8.
1. Reset value: hold `rst_n`=0, then release → `dout`=0x00000000, `locked`=0, `frame_cnt`=0, and neither pulse output is high.
2. Single frame: send words 0x11 (with `sof`), 0x22, 0x33, 0x44 on consecutive cycles → `dout`=0x44332211, then one `frame_valid` pulse one cycle after 0x44, then `locked`=1 and `frame_cnt`=1.
3. Gapped stream: send the same frame with `din_valid` low for 3 cycles between each word → identical `dout` and one pulse.
4. Premature start of frame: send 0xA0 (`sof`), 0xA1, then 0xB0 (`sof`), 0xB1, 0xB2, 0xB3 → `frame_err` pulses after 0xB0, then `dout`=0xB3B2B1B0 and exactly one `frame_valid`.
5. Missing start of frame after lock: after scenario 2, send 0x55 with `sof`=0 → word dropped, `frame_err` pulses, `locked`=0, `dout` still 0x44332211.
6. Continuous run and wrap: send 256 back-to-back frames at full rate → 256 `frame_valid` pulses spaced 4 cycles apart and `frame_cnt` wraps to 0. Assert `rst_n` during the 3rd word of a frame → all outputs return to their reset values.
